instruction_decoder: RTL and testbench

//  Single-cycle MIPS-subset control decoder. Splits a 32-bit instruction into register/immediate fields
//  and drives every datapath select and write enable (PC source, register destination, ALU op/operand,

---
 rtl/instruction_decoder_pkg.sv | 64 ++++++
 rtl/instruction_decoder.sv | 134 +++++++++++++
 tb/tb_instruction_decoder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_decoder_pkg.sv
// Shared encodings for the MIPS-subset control decoder: opcodes, funct codes,
// datapath select encodings and the default link register.
package instruction_decoder_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [4:0] LINK_REG_DEFAULT = 5'd31;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_XOR = 3'd2,
    ALU_SLT = 3'd3
  } aluCmd_t;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_REG    = 2'd1,
    PC_JUMP   = 2'd2,
    PC_BRANCH = 2'd3
  } pcSrc_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wbSrc_t;

  typedef struct packed {
    pcSrc_t  pcSrc;
    logic    regDst;
    logic    regWrEn;
    logic    extSel;
    logic    aluSrcB;
    aluCmd_t aluCommand;
    logic    memWrEn;
    wbSrc_t  writebackSrc;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    pcSrc:        PC_SEQ,
    regDst:       1'b0,
    regWrEn:      1'b0,
    extSel:       1'b0,
    aluSrcB:      1'b0,
    aluCommand:   ALU_ADD,
    memWrEn:      1'b0,
    writebackSrc: WB_ALU
  };

endpackage

// File: rtl/instruction_decoder.sv
// Single-cycle MIPS-subset control decoder with registered in-reset gating.
// Optional feature: define ILLEGAL_OP_TRAP_EN to add the sticky illegalOp output.
module instruction_decoder
  import instruction_decoder_pkg::*;
#(
  parameter logic [4:0] LINK_REG = LINK_REG_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        aluZero,
  output logic [1:0]  pcSrc,
  output logic        regDst,
  output logic        regWrEn,
  output logic        extSel,
  output logic        aluSrcB,
  output logic [2:0]  aluCommand,
  output logic        memWrEn,
  output logic [1:0]  writebackSrc,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic        illegalOp,
`endif
  output logic [27:0] jImm
);

  logic [5:0] opcode;
  logic [5:0] funct;
  ctrl_t      dec;
  ctrl_t      ctrl;
  logic       illegal;
  logic       inReset;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];

  always_comb begin
    dec     = CTRL_NOP;
    illegal = 1'b0;
    unique case (opcode)
      OP_LW: begin
        dec.regDst       = 1'b1;
        dec.regWrEn      = 1'b1;
        dec.extSel       = 1'b1;
        dec.aluSrcB      = 1'b1;
        dec.writebackSrc = WB_MEM;
      end
      OP_SW: begin
        dec.extSel  = 1'b1;
        dec.aluSrcB = 1'b1;
        dec.memWrEn = 1'b1;
      end
      OP_ADDI: begin
        dec.regDst  = 1'b1;
        dec.regWrEn = 1'b1;
        dec.extSel  = 1'b1;
        dec.aluSrcB = 1'b1;
      end
      OP_XORI: begin
        dec.regDst     = 1'b1;
        dec.regWrEn    = 1'b1;
        dec.aluSrcB    = 1'b1;
        dec.aluCommand = ALU_XOR;
      end
      OP_J: dec.pcSrc = PC_JUMP;
      OP_JAL: begin
        dec.pcSrc        = PC_JUMP;
        dec.regWrEn      = 1'b1;
        dec.writebackSrc = WB_LINK;
      end
      OP_BEQ, OP_BNE: begin
        dec.aluCommand = ALU_SUB;
        dec.extSel     = 1'b1;
        // BNE takes the branch on a nonzero compare, BEQ on zero
        if (aluZero ^ (opcode == OP_BNE)) dec.pcSrc = PC_BRANCH;
      end
      OP_RTYPE: begin
        unique case (funct)
          FN_ADD: dec.regWrEn = 1'b1;
          FN_SUB: begin
            dec.regWrEn    = 1'b1;
            dec.aluCommand = ALU_SUB;
          end
          FN_SLT: begin
            dec.regWrEn    = 1'b1;
            dec.aluCommand = ALU_SLT;
          end
          FN_JR:   dec.pcSrc = PC_REG;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    inReset <= !rst_n;
  end

`ifdef ILLEGAL_OP_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegalOp <= 1'b0;
    end else if (illegal && !inReset) begin
      illegalOp <= 1'b1;
    end
  end
`endif

  always_comb begin
    ctrl = dec;
    if (inReset) ctrl = CTRL_NOP;
  end

  assign pcSrc        = ctrl.pcSrc;
  assign regDst       = ctrl.regDst;
  assign regWrEn      = ctrl.regWrEn;
  assign extSel       = ctrl.extSel;
  assign aluSrcB      = ctrl.aluSrcB;
  assign aluCommand   = ctrl.aluCommand;
  assign memWrEn      = ctrl.memWrEn;
  assign writebackSrc = ctrl.writebackSrc;

  // Field outputs are not gated by reset; only JAL overrides rd
  assign rs   = instruction[25:21];
  assign rt   = instruction[20:16];
  assign rd   = (opcode == OP_JAL) ? LINK_REG : instruction[15:11];
  assign imm  = instruction[15:0];
  assign jImm = {instruction[25:0], 2'b00};

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed scoreboard bench for instruction_decoder; expected bundles are queued at
// drive time and popped when the outputs are sampled.
module tb_instruction_decoder;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic        aluZero;
  logic [1:0]  pcSrc;
  logic        regDst;
  logic        regWrEn;
  logic        extSel;
  logic        aluSrcB;
  logic [2:0]  aluCommand;
  logic        memWrEn;
  logic [1:0]  writebackSrc;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [27:0] jImm;
`ifdef ILLEGAL_OP_TRAP_EN
  logic        illegalOp;
`endif

  int unsigned checks;
  int unsigned passCount;
  int unsigned failCount;

  typedef struct {
    string      tag;
    logic [70:0] exp;
  } sbEntry_t;

  sbEntry_t sb[$];

  instruction_decoder #(.LINK_REG(5'd31)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instruction  (instruction),
    .aluZero      (aluZero),
    .pcSrc        (pcSrc),
    .regDst       (regDst),
    .regWrEn      (regWrEn),
    .extSel       (extSel),
    .aluSrcB      (aluSrcB),
    .aluCommand   (aluCommand),
    .memWrEn      (memWrEn),
    .writebackSrc (writebackSrc),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .imm          (imm),
`ifdef ILLEGAL_OP_TRAP_EN
    .illegalOp    (illegalOp),
`endif
    .jImm         (jImm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_LW    = 32'h8C2A0004;
  localparam logic [31:0] I_SW    = 32'hAC0A0008;
  localparam logic [31:0] I_SUB   = 32'h012A4022;
  localparam logic [31:0] I_ADD   = 32'h012A4020;
  localparam logic [31:0] I_SLT   = 32'h012A402A;
  localparam logic [31:0] I_BADFN = 32'h012A4021;
  localparam logic [31:0] I_BNE   = 32'h1509FFFE;
  localparam logic [31:0] I_BEQ   = 32'h1109FFFE;
  localparam logic [31:0] I_JAL   = 32'h0C000010;
  localparam logic [31:0] I_JR    = 32'h03E00008;
  localparam logic [31:0] I_J     = 32'h08000010;
  localparam logic [31:0] I_ADDI  = 32'h2149FFFF;
  localparam logic [31:0] I_XORI  = 32'h3949FFFF;
  localparam logic [31:0] I_BADOP = 32'hFC000000;

  function automatic logic [11:0] ctl(input logic [1:0] pc, input logic rdst, input logic rwe,
                                      input logic ext, input logic srcb, input logic [2:0] cmd,
                                      input logic mwe, input logic [1:0] wb);
    return {pc, rdst, rwe, ext, srcb, cmd, mwe, wb};
  endfunction

  function automatic logic [58:0] fld(input logic [31:0] ins, input logic jal);
    logic [4:0] r;
    r = jal ? 5'd31 : ins[15:11];
    return {ins[25:21], ins[20:16], r, ins[15:0], ins[25:0], 2'b00};
  endfunction

  task automatic apply(input string tag, input logic [31:0] ins, input logic z,
                       input logic [11:0] c, input logic jal);
    sbEntry_t e;
    instruction = ins;
    aluZero     = z;
    e.tag = tag;
    e.exp = {c, fld(ins, jal)};
    sb.push_back(e);
  endtask

  task automatic checkNext();
    sbEntry_t    e;
    logic [70:0] obs;
    obs = {pcSrc, regDst, regWrEn, extSel, aluSrcB, aluCommand, memWrEn, writebackSrc,
           rs, rt, rd, imm, jImm};
    checks++;
    if (sb.size() == 0) begin
      failCount++;
      $error("FAIL scoreboard_empty observed=%h expected=<queued entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) passCount++;
      else begin
        failCount++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input logic z,
                      input logic [11:0] c, input logic jal);
    @(negedge clk);
    apply(tag, ins, z, c, jal);
    #1 checkNext();
  endtask

  localparam logic [11:0] NOP = 12'h000;

  initial begin
    checks = 0; passCount = 0; failCount = 0;
    rst_n = 1'b0; instruction = '0; aluZero = 1'b0;

    @(negedge clk);
    apply("reset_sw_nop", I_SW, 1'b0, NOP, 1'b0);
    @(posedge clk);
    #1 checkNext();
`ifdef ILLEGAL_OP_TRAP_EN
    checkBit("illegal_reset", illegalOp, 1'b0);
`endif

    // flag still set until the first edge with rst_n high
    @(negedge clk);
    rst_n = 1'b1;
    apply("sw_before_release_edge", I_SW, 1'b0, NOP, 1'b0);
    #1 checkNext();
    @(posedge clk);
    #1 apply("sw_after_release", I_SW, 1'b0, ctl(2'd0, 0, 0, 1, 1, 3'd0, 1, 2'd0), 1'b0);
    checkNext();

    step("lw",      I_LW,   1'b0, ctl(2'd0, 1, 1, 1, 1, 3'd0, 0, 2'd1), 1'b0);
    step("sub",     I_SUB,  1'b0, ctl(2'd0, 0, 1, 0, 0, 3'd1, 0, 2'd0), 1'b0);
    step("add",     I_ADD,  1'b1, ctl(2'd0, 0, 1, 0, 0, 3'd0, 0, 2'd0), 1'b0);
    step("slt",     I_SLT,  1'b0, ctl(2'd0, 0, 1, 0, 0, 3'd3, 0, 2'd0), 1'b0);
    step("bne_z0",  I_BNE,  1'b0, ctl(2'd3, 0, 0, 1, 0, 3'd1, 0, 2'd0), 1'b0);
    step("bne_z1",  I_BNE,  1'b1, ctl(2'd0, 0, 0, 1, 0, 3'd1, 0, 2'd0), 1'b0);
    step("beq_z1",  I_BEQ,  1'b1, ctl(2'd3, 0, 0, 1, 0, 3'd1, 0, 2'd0), 1'b0);
    step("beq_z0",  I_BEQ,  1'b0, ctl(2'd0, 0, 0, 1, 0, 3'd1, 0, 2'd0), 1'b0);
    step("jal",     I_JAL,  1'b0, ctl(2'd2, 0, 1, 0, 0, 3'd0, 0, 2'd2), 1'b1);
    step("jr",      I_JR,   1'b0, ctl(2'd1, 0, 0, 0, 0, 3'd0, 0, 2'd0), 1'b0);
    step("j",       I_J,    1'b1, ctl(2'd2, 0, 0, 0, 0, 3'd0, 0, 2'd0), 1'b0);
    step("addi",    I_ADDI, 1'b0, ctl(2'd0, 1, 1, 1, 1, 3'd0, 0, 2'd0), 1'b0);
    step("xori",    I_XORI, 1'b0, ctl(2'd0, 1, 1, 0, 1, 3'd2, 0, 2'd0), 1'b0);
    step("bad_fn",  I_BADFN,1'b0, NOP, 1'b0);
`ifdef ILLEGAL_OP_TRAP_EN
    @(posedge clk);
    #1 checkBit("illegal_after_bad_fn", illegalOp, 1'b1);
`endif
    step("bad_op",  I_BADOP,1'b0, NOP, 1'b0);
`ifdef ILLEGAL_OP_TRAP_EN
    @(posedge clk);
    #1 checkBit("illegal_after_bad_op", illegalOp, 1'b1);
`endif
    step("lw_after_bad", I_LW, 1'b0, ctl(2'd0, 1, 1, 1, 1, 3'd0, 0, 2'd1), 1'b0);
`ifdef ILLEGAL_OP_TRAP_EN
    @(posedge clk);
    #1 checkBit("illegal_sticky", illegalOp, 1'b1);
`endif

    // mid-program reset: current decode stands until the edge
    @(negedge clk);
    rst_n = 1'b0;
    apply("lw_reset_pending", I_LW, 1'b0, ctl(2'd0, 1, 1, 1, 1, 3'd0, 0, 2'd1), 1'b0);
    #1 checkNext();
    @(posedge clk);
    #1 apply("lw_in_reset", I_LW, 1'b0, NOP, 1'b0);
    checkNext();
`ifdef ILLEGAL_OP_TRAP_EN
    checkBit("illegal_cleared", illegalOp, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 apply("lw_after_reset", I_LW, 1'b0, ctl(2'd0, 1, 1, 1, 1, 3'd0, 0, 2'd1), 1'b0);
    checkNext();

    $display("%0d/%0d checks passed", passCount, checks);
    $finish;
  end

endmodule
